lut_regfile: RTL and testbench
==============================

// Module: lut_regfile
// PURPOSE
//  Writable, parametrised successor to the fixed 8-entry constant table.
//  Holds DEPTH signed constants of WIDTH bits, indexed by a small opcode field.
//  Reset and a restore command reload the ISA default constants.
//  Reads are registered (1-cycle) with a valid strobe; entries are runtime-writable.
//  Sits beside the decoder, feeding immediate operands to the ALU mux.
// PARAMETERS
//  WIDTH  8   data width in bits; >=8; defaults are sign-extended to WIDTH
//  DEPTH  8   number of entries; >=2
//  IDXW   $clog2(DEPTH)  index width (derived, do not override)
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous active-low reset
//  rd_req          in   1      read request
//  rd_idx          in   IDXW   read index
//  rd_valid        out  1      rd_data valid, one cycle after an accepted rd_req
//  rd_data         out  WIDTH  read data, held between reads
//  wr_en           in   1      write strobe
//  wr_idx          in   IDXW   write index
//  wr_data         in   WIDTH  write data
//  restore         in   1      pulse: reload all defaults
//  busy            out  1      high while a restore is in progress
//  wr_prot         in   1      (LUT_WRPROT_EN) with wr_en: set protect bit of wr_idx, no data write
//  wr_err          out  1      (LUT_WRPROT_EN) 1-cycle pulse: write to protected entry dropped
// BEHAVIOUR
//  Defaults, index 0..7: 100, 10, 5, 1, 0, -1, -30, -5.
//   Entries >=8 default to 0; DEPTH<8 keeps only the first DEPTH defaults.
//  Reset (rst_n=0, async): every entry takes its default.
//   Outputs: rd_valid=0, rd_data=0, busy=0, wr_err=0; FSM=IDLE; all protect bits=0.
//  Read: in IDLE, rd_req=1 is accepted.
//   Next edge: rd_valid=1, rd_data=entry[rd_idx]; otherwise rd_valid=0.
//  Write: in IDLE, wr_en=1 updates entry[wr_idx] at the edge.
//  Same-cycle rd/wr to the same index: write-first, so rd_data = wr_data.
//  rd_idx/wr_idx >= DEPTH: read returns 0 with rd_valid=1; write is ignored.
//  FSM IDLE->RESTORE on restore=1 (restore beats a same-cycle wr_en; the write is dropped).
//  RESTORE: ptr runs 0..DEPTH-1, writing one default per cycle; busy=1.
//   After ptr=DEPTH-1 the FSM returns to IDLE; busy falls DEPTH cycles after the restore edge.
//  While busy: rd_req, wr_en and restore are ignored; rd_valid=0.
//  Reset during RESTORE: async reload of all entries, FSM=IDLE, ptr=0.
// CONFIGURATION
//  LUT_WRPROT_EN defined:
//   - one protect bit per entry; wr_en & wr_prot sets the bit for wr_idx.
//   - wr_en to a protected index: data unchanged, wr_err pulses 1 cycle.
//   - restore rewrites protected entries too; protect bits clear only on reset.
//  LUT_WRPROT_EN undefined:
//   - wr_prot is ignored; wr_err is tied 0; no protect storage.
// TESTING
//  1 Reset, then read idx 0..7 -> rd_data 100,10,5,1,0,-1,-30,-5 (0x64..0xFB); rd_valid 1 cycle after each req.
//  2 Write idx3=0x7F, then read idx3 -> 0x7F; same-cycle wr idx5=0x11 and rd idx5 -> rd_data 0x11.
//  3 Overwrite idx0..7, pulse restore -> busy=1 for exactly 8 cycles.
//    During busy: rd_req gives rd_valid=0 and wr_en is dropped; afterwards all reads return the defaults.
//  4 restore and wr_en idx2=0x33 in the same cycle -> write dropped; idx2 reads 5 after busy falls.
//  5 Assert rst_n=0 mid-restore (ptr=3) with idx6 modified -> idx6 immediately -30, busy=0.
//  6 [LUT_WRPROT_EN] Protect idx1, then write idx1=0x00 -> wr_err pulse, idx1 still 10.
//    A restore keeps the protect bit; reset clears it.

Source files
------------

// File: rtl/lut_regfile.sv
// Writable table of DEPTH signed constants with registered reads and a multi-cycle restore of the ISA defaults.
// Optional per-entry write protection is enabled by defining LUT_WRPROT_EN.
module lut_regfile #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  logic [IDXW-1:0]  rd_idx,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             restore,
  output logic             busy,
  input  logic             wr_prot,
  output logic             wr_err
);

  typedef enum logic {
    ST_IDLE,
    ST_RESTORE
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  // ISA default for an entry; indices past the original eight default to zero.
  function automatic logic [WIDTH-1:0] default_val(input int idx);
    int v;
    case (idx)
      0:       v = 100;
      1:       v = 10;
      2:       v = 5;
      3:       v = 1;
      5:       v = -1;
      6:       v = -30;
      7:       v = -5;
      default: v = 0;
    endcase
    return WIDTH'(v);
  endfunction

  state_t           state;
  logic [IDXW-1:0]  ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic idle;
  logic rd_in_range;
  logic wr_in_range;
  logic rd_accept;
  logic wr_request;
  logic wr_commit;

  assign idle = (state == ST_IDLE);

  generate
    if (DEPTH == (1 << IDXW)) begin : g_full_range
      assign rd_in_range = 1'b1;
      assign wr_in_range = 1'b1;
    end else begin : g_partial_range
      assign rd_in_range = (int'(rd_idx) < DEPTH);
      assign wr_in_range = (int'(wr_idx) < DEPTH);
    end
  endgenerate

  assign rd_accept  = idle && rd_req;
  assign wr_request = idle && wr_en && !restore && wr_in_range;

`ifdef LUT_WRPROT_EN
  logic [DEPTH-1:0] prot;
  logic             prot_set;
  logic             prot_block;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    prot_set   = 1'b0;
    prot_block = 1'b0;
    wr_commit  = 1'b0;
    if (wr_request) begin
      if (wr_prot) begin
        prot_set = 1'b1;
      end else if (prot[wr_idx]) begin
        prot_block = 1'b1;
      end else begin
        wr_commit = 1'b1;
      end
    end
  end

  // Protect bits survive restore; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prot   <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= prot_block;
      if (prot_set) begin
        prot[wr_idx] <= 1'b1;
      end
    end
  end
`else
  logic unused_wr_prot;

  assign unused_wr_prot = wr_prot;
  assign wr_commit      = wr_request;
  assign wr_err         = 1'b0;
`endif

  // NOTE: the table resets to the defaults rather than to zero, so the storage
  // array carries the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= default_val(i);
      end
    end else if (state == ST_RESTORE) begin
      mem[ptr] <= default_val(int'(ptr));
    end else if (wr_commit) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (restore) begin
            state <= ST_RESTORE;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RESTORE: begin
          if (ptr == LAST_IDX) begin
            state <= ST_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write-first: a same-cycle write to the read index forwards wr_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        if (!rd_in_range) begin
          rd_data <= '0;
        end else if (wr_commit && (wr_idx == rd_idx)) begin
          rd_data <= wr_data;
        end else begin
          rd_data <= mem[rd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_regfile.sv
// Directed bench for lut_regfile: a table-level model checked every cycle plus literal spot checks.
// Define LUT_WRPROT_EN for both files to exercise write protection.
module tb_lut_regfile;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic          clk;
  logic          rst_n;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic          restore;
  logic          busy;
  logic          wr_prot;
  logic          wr_err;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  lut_regfile #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .restore  (restore),
    .busy     (busy),
    .wr_prot  (wr_prot),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Table-level model: restore reloads the whole table at once and just counts busy cycles.
  int           defaults [DEPTH] = '{100, 10, 5, 1, 0, -1, -30, -5};
  logic [W-1:0] m_mem [DEPTH];
  bit           m_prot [DEPTH];
  int           m_busy_left;
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_wr_err;

  always @(posedge clk or negedge rst_n) begin
    bit wok;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = W'(defaults[i]);
        m_prot[i] = 1'b0;
      end
      m_busy_left = 0;
      m_valid     = 1'b0;
      m_data      = '0;
      m_wr_err    = 1'b0;
    end else begin
      m_valid  = 1'b0;
      m_wr_err = 1'b0;
      if (m_busy_left > 0) begin
        m_busy_left = m_busy_left - 1;
      end else begin
        wok = wr_en && !restore;
`ifdef LUT_WRPROT_EN
        if (wok && wr_prot) begin
          m_prot[wr_idx] = 1'b1;
          wok = 1'b0;
        end else if (wok && m_prot[wr_idx]) begin
          m_wr_err = 1'b1;
          wok = 1'b0;
        end
`endif
        if (rd_req) begin
          m_valid = 1'b1;
          m_data  = (wok && wr_idx == rd_idx) ? wr_data : m_mem[rd_idx];
        end
        if (wok) m_mem[wr_idx] = wr_data;
        if (restore) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = W'(defaults[i]);
          m_busy_left = DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model rd_valid", int'(rd_valid), int'(m_valid));
      check("model rd_data",  int'(rd_data),  int'(m_data));
      check("model busy",     int'(busy),     int'(m_busy_left > 0));
      check("model wr_err",   int'(wr_err),   int'(m_wr_err));
    end
  end

  logic [W-1:0] lit_defaults [DEPTH] = '{8'h64, 8'h0A, 8'h05, 8'h01, 8'h00, 8'hFF, 8'hE2, 8'hFB};

  task automatic do_read(input logic [IW-1:0] idx, input logic [W-1:0] exp, input string name);
    @(negedge clk);
    rd_req = 1'b1;
    rd_idx = idx;
    @(negedge clk);
    rd_req = 1'b0;
    check({name, " valid"}, int'(rd_valid), 1);
    check({name, " data"}, int'(rd_data), int'(exp));
  endtask

  task automatic do_write(input logic [IW-1:0] idx, input logic [W-1:0] data, input logic prot);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    wr_prot = prot;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_prot = 1'b0;
  endtask

  task automatic pulse_restore();
    @(negedge clk);
    restore = 1'b1;
    @(negedge clk);
    restore = 1'b0;
  endtask

  // Counts negedges with busy high; entered at the first negedge after the restore edge.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) check("busy timeout", int'(busy), 0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    rd_req  = 1'b0;
    rd_idx  = '0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    restore = 1'b0;
    wr_prot = 1'b0;
    repeat (2) @(negedge clk);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset rd_data",  int'(rd_data),  0);
    check("reset busy",     int'(busy),     0);
    check("reset wr_err",   int'(wr_err),   0);
    rst_n = 1'b1;
    check_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) do_read(IW'(i), lit_defaults[i], "default read");

    do_write(3'd3, 8'h7F, 1'b0);
    do_read(3'd3, 8'h7F, "write idx3");
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 3'd5; wr_data = 8'h11;
    rd_req = 1'b1; rd_idx = 3'd5;
    @(negedge clk);
    wr_en = 1'b0; rd_req = 1'b0;
    check("write-first valid", int'(rd_valid), 1);
    check("write-first data",  int'(rd_data),  8'h11);

    for (int i = 0; i < DEPTH; i++) do_write(IW'(i), W'(8'hA0 + i), 1'b0);
    pulse_restore();
    n = 0;
    while (busy && n < 40) begin
      check("busy rd_valid", int'(rd_valid), 0);
      rd_req = 1'b1; rd_idx = 3'd0;
      wr_en = 1'b1; wr_idx = 3'd0; wr_data = 8'h99;
      n++;
      @(negedge clk);
    end
    rd_req = 1'b0; wr_en = 1'b0;
    check("busy cycles", n, 8);
    for (int i = 0; i < DEPTH; i++) do_read(IW'(i), lit_defaults[i], "restored read");

    do_write(3'd2, 8'h44, 1'b0);
    @(negedge clk);
    restore = 1'b1; wr_en = 1'b1; wr_idx = 3'd2; wr_data = 8'h33;
    @(negedge clk);
    restore = 1'b0; wr_en = 1'b0;
    wait_idle(n);
    check("restore+write busy cycles", n, 8);
    do_read(3'd2, 8'h05, "restore beats write");

    do_write(3'd6, 8'h12, 1'b0);
    do_read(3'd6, 8'h12, "idx6 modified");
    pulse_restore();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-restore reset busy", int'(busy), 0);
    check("mid-restore reset rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(3'd6, 8'hE2, "idx6 after reset");

`ifdef LUT_WRPROT_EN
    do_write(3'd1, 8'h55, 1'b1);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 3'd1; wr_data = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    check("protected wr_err", int'(wr_err), 1);
    @(negedge clk);
    check("wr_err one pulse", int'(wr_err), 0);
    do_read(3'd1, 8'h0A, "protected idx1");
    pulse_restore();
    wait_idle(n);
    do_write(3'd1, 8'h00, 1'b0);
    check("prot kept wr_err", int'(wr_err), 1);
    do_read(3'd1, 8'h0A, "prot kept idx1");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_write(3'd1, 8'h00, 1'b0);
    check("prot cleared wr_err", int'(wr_err), 0);
    do_read(3'd1, 8'h00, "prot cleared idx1");
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
